// File: rtl/line_buffer_kxk_if.sv
// Pixel stream in, vertical tap column plus position tags out, for the K-row line buffer.
// No backpressure in either direction; the source owns valid_in/sof_in/din/cfg_width.
interface line_buffer_kxk_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int KERNEL     = 3,
  parameter int CW         = $clog2(MAX_WIDTH + 1)
);
  logic [CW-1:0]                cfg_width;
  logic                         valid_in;
  logic                         sof_in;
  logic [DATA_WIDTH-1:0]        din;
  logic [KERNEL*DATA_WIDTH-1:0] dout;
  logic                         valid_out;
  logic [CW-1:0]                col_out;
  logic [15:0]                  row_out;
  logic                         eol_out;
  logic                         rows_ready;

  modport master (
    output cfg_width, valid_in, sof_in, din,
    input  dout, valid_out, col_out, row_out, eol_out, rows_ready
  );

  modport slave (
    input  cfg_width, valid_in, sof_in, din,
    output dout, valid_out, col_out, row_out, eol_out, rows_ready
  );
endinterface

// File: rtl/line_buffer_kxk.sv
// K-row line buffer: emits a registered column of KERNEL vertically aligned pixels, 1-cycle latency.
// Accepts one pixel per valid_in with no backpressure; runtime width latched on sof_in.
module line_buffer_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int KERNEL     = 3,
  parameter int CW         = $clog2(MAX_WIDTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  line_buffer_kxk_if.slave  bus
);

  localparam int            AW        = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CW-1:0] MAXW      = CW'(MAX_WIDTH);
  localparam logic [15:0]   ROWS_FULL = 16'(KERNEL - 1);

  logic [CW-1:0]                r_ptr;
  logic [CW-1:0]                r_width;
  logic [15:0]                  r_row;
  logic [KERNEL*DATA_WIDTH-1:0] r_dout;
  logic                         r_valid_out;
  logic [CW-1:0]                r_col_out;
  logic [15:0]                  r_row_out;
  logic                         r_eol_out;

  logic [CW-1:0]                w_new_width;
  logic [CW-1:0]                w_width;
  logic [CW-1:0]                w_col;
  logic [15:0]                  w_row;
  logic [15:0]                  w_row_inc;
  logic                         w_last;
  logic                         w_full;
  logic [KERNEL*DATA_WIDTH-1:0] w_column;
  // w_tap[KERNEL-1] is the live pixel; lower taps are the line memories, oldest at 0.
  logic [DATA_WIDTH-1:0]        w_tap [KERNEL];

  // A sof pixel restarts at column 0 / row 0 and already uses the width it carries.
  always_comb begin
    w_new_width = (bus.cfg_width == '0 || bus.cfg_width > MAXW) ? MAXW : bus.cfg_width;
    w_width     = bus.sof_in ? w_new_width : r_width;
    w_col       = bus.sof_in ? '0 : r_ptr;
    w_row       = bus.sof_in ? '0 : r_row;
    w_last      = (w_col == w_width - CW'(1));
    w_row_inc   = (w_row == 16'hFFFF) ? w_row : w_row + 16'd1;
    w_full      = (w_row >= ROWS_FULL);
  end

  assign w_tap[KERNEL-1] = bus.din;

  // Each memory reads its column then takes the value from the line above it.
  for (genvar k = 0; k < KERNEL - 1; k++) begin : g_line
    logic [DATA_WIDTH-1:0] r_mem [MAX_WIDTH];

    assign w_tap[k] = r_mem[w_col[AW-1:0]];

    always_ff @(posedge clk) begin
      if (bus.valid_in) begin
        r_mem[w_col[AW-1:0]] <= w_tap[k+1];
      end
    end
  end

  always_comb begin
    w_column = '0;
    for (int j = 0; j < KERNEL; j++) begin
      w_column[j*DATA_WIDTH +: DATA_WIDTH] = w_tap[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_width     <= MAXW;
      r_row       <= '0;
      r_dout      <= '0;
      r_valid_out <= 1'b0;
      r_col_out   <= '0;
      r_row_out   <= '0;
      r_eol_out   <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_eol_out   <= 1'b0;
      if (bus.valid_in) begin
        r_width     <= w_width;
        r_ptr       <= w_last ? '0 : w_col + CW'(1);
        r_row       <= w_last ? w_row_inc : w_row;
        r_dout      <= w_column;
        r_col_out   <= w_col;
        r_row_out   <= w_row;
        // Rows below KERNEL-1 would expose stale lines from an earlier frame.
        r_valid_out <= w_full;
        r_eol_out   <= w_full && w_last;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.valid_out  = r_valid_out;
  assign bus.col_out    = r_col_out;
  assign bus.row_out    = r_row_out;
  assign bus.eol_out    = r_eol_out;
  assign bus.rows_ready = (r_row >= ROWS_FULL);

endmodule

// File: tb/tb_line_buffer_kxk.sv
// Randomised scoreboard bench for line_buffer_kxk against a frame-image reference model.
module tb_line_buffer_kxk;

  localparam int DW = 8;
  localparam int MW = 16;
  localparam int K  = 3;
  localparam int CW = $clog2(MW + 1);

  typedef struct {
    logic [K*DW-1:0] dat;
    int              col;
    int              row;
    bit              eol;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_valid = 0;

  exp_t    sb [$];
  logic [DW-1:0] img [int];
  int      m_width = MW;
  int      m_col = 0;
  int      m_row = 0;

  line_buffer_kxk_if #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .KERNEL(K)) bus ();

  line_buffer_kxk #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .KERNEL(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the current frame as a 2-D image; a valid column is just rows r-K+1..r at column c.
  task automatic model_accept(input bit sof, input logic [DW-1:0] d, input int w);
    int   c;
    int   r;
    exp_t e;
    if (sof) begin
      m_width = (w == 0 || w > MW) ? MW : w;
      img.delete();
      c = 0;
      r = 0;
    end else begin
      c = m_col;
      r = m_row;
    end
    img[r*1024 + c] = d;
    if (r >= K - 1) begin
      e.dat = '0;
      for (int j = 0; j < K; j++) e.dat[j*DW +: DW] = img[(r - (K - 1) + j)*1024 + c];
      e.col = c;
      e.row = r;
      e.eol = (c == m_width - 1);
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (c == m_width - 1) begin
      m_col = 0;
      m_row = (r < 65535) ? r + 1 : r;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
  endtask

  task automatic pix(input bit v, input bit sof, input logic [DW-1:0] d, input int w);
    @(posedge clk);
    #1;
    bus.valid_in  = v;
    bus.sof_in    = sof;
    bus.din       = d;
    bus.cfg_width = CW'(w);
    if (v) model_accept(sof, d, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 8'(i), int'($urandom_range(0, 31)));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dout"}, 64'(bus.dout), 64'd0);
    chk({tag, "_valid_out"}, 64'(bus.valid_out), 64'd0);
    chk({tag, "_col_out"}, 64'(bus.col_out), 64'd0);
    chk({tag, "_row_out"}, 64'(bus.row_out), 64'd0);
    chk({tag, "_eol_out"}, 64'(bus.eol_out), 64'd0);
    chk({tag, "_rows_ready"}, 64'(bus.rows_ready), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    sb.delete();
    img.delete();
    m_width = MW;
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic basic_fill(input string tag, input bit gapped);
    int base;
    base = n_valid;
    for (int i = 0; i < 16; i++) begin
      pix(1'b1, i == 0, 8'(i), 4);
      if (gapped) pix(1'b0, 1'b0, 8'hAA, 7);
    end
    idle(3);
    chk({tag, "_valid_count"}, 64'(n_valid - base), 64'd8);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a column.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid_out: got col %0d row %0d, none required", bus.col_out, bus.row_out);
      end else begin
        e = sb.pop_front();
        chk("out_cycle", 64'(cyc), 64'(e.cyc + 1));
        chk("dout", 64'(bus.dout), 64'(e.dat));
        chk("col_out", 64'(bus.col_out), 64'(e.col));
        chk("row_out", 64'(bus.row_out), 64'(e.row));
        chk("eol_out", 64'(bus.eol_out), 64'(e.eol));
      end
    end else if (rst_n === 1'b1) begin
      chk("eol_idle", 64'(bus.eol_out), 64'd0);
      if (sb.size() != 0 && sb[0].cyc + 1 < cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_valid_out: got none, required col %0d row %0d", e.col, e.row);
      end
    end
  end

  initial begin
    int v;
    int s;
    bus.valid_in  = 1'b0;
    bus.sof_in    = 1'b0;
    bus.din       = '0;
    bus.cfg_width = '0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    basic_fill("fill", 1'b0);
    basic_fill("gapped", 1'b1);

    // Mid-line restart at row 2, column 2.
    for (int i = 0; i < 10; i++) pix(1'b1, i == 0, 8'(i), 4);
    pix(1'b0, 1'b0, 8'h0, 4);
    @(negedge clk);
    chk("rows_ready_before_restart", 64'(bus.rows_ready), 64'd1);
    pix(1'b1, 1'b1, 8'd10, 4);
    pix(1'b0, 1'b0, 8'h0, 4);
    @(negedge clk);
    chk("rows_ready_after_restart", 64'(bus.rows_ready), 64'd0);
    for (int i = 11; i < 26; i++) pix(1'b1, 1'b0, 8'(i), 9);
    idle(2);

    // Width clamp: 0 and 20 both latch MAX_WIDTH.
    for (int i = 0; i < 48; i++) pix(1'b1, i == 0, 8'(i + 100), 0);
    idle(2);
    for (int i = 0; i < 48; i++) pix(1'b1, i == 0, 8'(i + 50), 20);
    idle(2);

    // Width 1: every pixel closes a line.
    for (int i = 0; i < 8; i++) pix(1'b1, i == 0, 8'(i + 10), 1);
    idle(2);

    // Reset in row 3, then the basic fill again.
    for (int i = 0; i < 14; i++) pix(1'b1, i == 0, 8'(i + 200), 4);
    do_reset();
    basic_fill("post_reset", 1'b0);

    // Random traffic: widths 0..20, gaps, occasional frame restarts.
    pix(1'b1, 1'b1, 8'($urandom), int'($urandom_range(0, 20)));
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s = ($urandom_range(0, 79) == 0) ? 1 : 0;
      pix(v[0], s[0], 8'($urandom), int'($urandom_range(0, 20)));
    end
    idle(2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_buffer_kxk.md
# line_buffer_kxk

Parametrised K-row line buffer for sliding-window image kernels (Sobel, Gaussian, median, up to 7x7). It accepts one pixel per `valid_in` strobe in raster order and presents a registered vertical column of `KERNEL` vertically aligned pixels. Unlike the fixed 3-row Sobel buffer, it adds:

- runtime line width;
- frame-start resynchronisation;
- row/column position tags;
- an end-of-line marker.

It sits between the pixel source and the window/shift-register stage of each filter.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits.
- `MAX_WIDTH`, 1024, maximum line length; sets RAM depth.
- `KERNEL`, 3, number of rows output; legal 2..7.
- `CW`, `$clog2(MAX_WIDTH+1)`, width of column/width fields.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_width`  in  CW  active line length; sampled only on an accepted `sof_in` pixel.
- `valid_in`  in  1  pixel strobe; no backpressure.
- `sof_in`  in  1  first pixel of frame; qualified by `valid_in`.
- `din`  in  DATA_WIDTH  pixel.
- `dout`  out  KERNEL*DATA_WIDTH  column taps; slice j = row (r-(KERNEL-1)+j); slice KERNEL-1 = current pixel; slice 0 = oldest.
- `valid_out`  out  1  `dout` holds a full, valid column.
- `col_out`  out  CW  column index of `dout`.
- `row_out`  out  16  row index of the current pixel, saturating at 65535.
- `eol_out`  out  1  `dout` column is the last of its line.
- `rows_ready`  out  1  level; high once KERNEL-1 complete rows of the current frame are buffered.

## Operation
**Storage**
- KERNEL-1 line memories `lb[0..KERNEL-2]`, each MAX_WIDTH deep, sharing one column pointer `ptr`.
- On each accepted pixel at `ptr`: `lb[k][ptr] <= lb[k+1][ptr]` for k < KERNEL-2, and `lb[KERNEL-2][ptr] <= din`.
- Reads happen before writes in the same cycle. Taps are `lb[0..KERNEL-2][ptr]` followed by `din`.

**Width**
- Register `width_q` resets to MAX_WIDTH.
- On accepted `sof_in`, `width_q <= cfg_width`, except 0 or > MAX_WIDTH latch MAX_WIDTH.
- `cfg_width` is ignored at all other times.

**Pointer and row**
- An accepted pixel with `sof_in` is written at column 0 regardless of the current `ptr`; that pixel is row 0.
- The pointer then advances from 0 using the newly latched width.
- On a non-sof accepted pixel, `ptr` increments. When `ptr == width_q-1`, `ptr` wraps to 0 and the row counter increments, saturating.
- A pixel at the last column is the end of its line.

**Validity**
- A pixel is valid for output when its row ≥ KERNEL-1.
- Memory is never cleared: stale contents from a previous frame are masked by the row gating, not erased.
- `rows_ready` = (row counter ≥ KERNEL-1). It drops to 0 on the cycle after an accepted `sof_in`.
- A mid-line `sof_in` abandons the partial line and frame. It behaves exactly like the first `sof_in` after reset.

**Idle**
- With `valid_in` low, memories, `ptr` and counters hold.
- `dout`, `col_out` and `row_out` hold their last values; `valid_out` and `eol_out` are 0.

## Timing
- **Latency:** output registers load on the clock edge that accepts the pixel, so outputs reflect it from the next cycle (1 cycle).
- `valid_out` and `eol_out` are single-cycle pulses aligned with the corresponding `dout`.
- **Reset values:** all outputs 0; `ptr` 0; row counter 0; `width_q` MAX_WIDTH. Memory contents are undefined.
- Reset may assert at any time, including mid-line. After release, `valid_out` stays low until KERNEL-1 full rows have been received.
- `valid_in` may be high every cycle; throughput is 1 pixel/clock.
- **Simultaneous `sof_in` with a wrap condition:** `sof_in` wins. `ptr` goes to 1 (or wraps to 0 if the new width is 1); row stays 0.
- **Width 1:** every pixel is end-of-line; row increments on every accepted pixel.

## Test plan
- **Basic fill, 3x3:** KERNEL=3, `cfg_width`=4, `sof_in` on the first pixel, feed 0,1,2,…,15.
  - No `valid_out` for the first 8 pixels.
  - Pixel 8 → `dout` = {8,4,0} (slice2..slice0), `col_out`=0, `row_out`=2, next cycle.
  - Pixel 11 → `eol_out`=1.
- **Gapped input:** same stimulus with `valid_in` toggled every other cycle → identical output sequence; `valid_out` only on the cycle after each accepted pixel.
- **Mid-line frame restart:** width 4, `sof_in` reasserted at pixel 10 (row 2, col 2).
  - `rows_ready` drops.
  - The next valid output appears only 8 accepted pixels later, with `col_out`=0, `row_out`=2.
  - No stale columns emitted.
- **Width clamp:** `cfg_width`=0 at `sof_in`, MAX_WIDTH=16 → wrap after 16 pixels, first `eol_out` on the 16th valid column.
  - Repeat with `cfg_width`=20 → same result.
- **5x5 and width 1:** KERNEL=5, `cfg_width`=1, feed 10,11,…
  - The first `valid_out` occurs after pixel 14, with `dout` = {14,13,12,11,10}.
  - `eol_out`=1 on every valid output.
- **Async reset mid-frame:** assert `rst_n` low for 1 cycle at row 3.
  - All outputs 0 immediately.
  - After release with a new `sof_in`, behaviour matches the basic fill scenario exactly.
